multi_rect_renderer: RTL and testbench

Parametrised successor to the single-rectangle stage in the render chain: holds up to NUM_RECTS rectangles, each with its own geometry, colour, enable and blend mode, and overlays them onto the pixel stream flowing through the daisy chain. Shapes are programmed in-band over the same program/x/y/data bus. Writes land in shadow registers and become visible atomically at the next frame start, so a frame never renders with a half-updated shape. The stage is a 2-cycle pipeline and drops into the chain in place of a single-rect stage.

---
 rtl/multi_rect_renderer.sv | 109 ++++++++++
 tb/tb_multi_rect_renderer.sv | 104 ++++++++++
 2 files changed

// File: rtl/multi_rect_renderer.sv
// multi_rect_renderer: overlays up to NUM_RECTS double-buffered rectangles onto a daisy-chained pixel stream, 2-cycle latency.
module multi_rect_renderer #(
  parameter int NUM_RECTS = 4,
  parameter int X_W = 11,
  parameter int Y_W = 12,
  parameter int COLOR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               program_in,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [COLOR_W-1:0] data_in,
  output logic               program_out,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] data_out
);
  localparam int SLOT_W = NUM_RECTS > 1 ? $clog2(NUM_RECTS) : 1;
  localparam int NB = COLOR_W / 8;
  localparam logic [SLOT_W:0] NR = (SLOT_W + 1)'(NUM_RECTS);
  logic [X_W:0]     sh_xc [NUM_RECTS], sh_w [NUM_RECTS], ac_xc [NUM_RECTS], ac_w [NUM_RECTS], e_xc [NUM_RECTS], e_w [NUM_RECTS];
  logic [Y_W:0]     sh_yc [NUM_RECTS], sh_h [NUM_RECTS], ac_yc [NUM_RECTS], ac_h [NUM_RECTS], e_yc [NUM_RECTS], e_h [NUM_RECTS];
  logic [COLOR_W-1:0] sh_col [NUM_RECTS], ac_col [NUM_RECTS], e_col [NUM_RECTS];
  logic [1:0]       sh_ctl [NUM_RECTS], ac_ctl [NUM_RECTS], e_ctl [NUM_RECTS];
  logic             pending;
  logic [NUM_RECTS-1:0] hit, m1;
  logic [COLOR_W-1:0] sel_col, c1, d1, avg;
  logic             sel_blend, b1, p1;
  logic [X_W-1:0]   x1;
  logic [Y_W-1:0]   y1;
  logic [8:0]       bsum [NB];
  logic [2:0]       reg_id;
  logic [SLOT_W-1:0] slot;
  logic             addr_hit, slot_ok, commit_now;
  assign reg_id = y[2:0];
  assign slot = y[3 +: SLOT_W];
  assign slot_ok = {1'b0, slot} < NR;
  assign addr_hit = program_in && x == '0;
  assign commit_now = !program_in && x == '0 && y == '0 && pending;
  // The frame-start pixel itself must see the freshly committed shapes.
  always_comb begin
    hit = '0;
    sel_col = '0;
    sel_blend = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      e_xc[i] = commit_now ? sh_xc[i] : ac_xc[i];
      e_yc[i] = commit_now ? sh_yc[i] : ac_yc[i];
      e_w[i] = commit_now ? sh_w[i] : ac_w[i];
      e_h[i] = commit_now ? sh_h[i] : ac_h[i];
      e_col[i] = commit_now ? sh_col[i] : ac_col[i];
      e_ctl[i] = commit_now ? sh_ctl[i] : ac_ctl[i];
      hit[i] = !program_in && e_ctl[i][0]
        && {1'b0, x} >= e_xc[i] && {2'b0, x} < {1'b0, e_xc[i]} + {1'b0, e_w[i]}
        && {1'b0, y} >= e_yc[i] && {2'b0, y} < {1'b0, e_yc[i]} + {1'b0, e_h[i]};
      sel_col = hit[i] ? e_col[i] : sel_col;
      sel_blend = hit[i] ? e_ctl[i][1] : sel_blend;
    end
  end
  always_comb begin
    avg = '0;
    for (int b = 0; b < NB; b++) begin
      bsum[b] = {1'b0, c1[8*b +: 8]} + {1'b0, d1[8*b +: 8]};
      avg[8*b +: 8] = bsum[b][8:1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_xc[i] <= '0; sh_yc[i] <= '0; sh_w[i] <= '0; sh_h[i] <= '0; sh_col[i] <= '1; sh_ctl[i] <= '0;
        ac_xc[i] <= '0; ac_yc[i] <= '0; ac_w[i] <= '0; ac_h[i] <= '0; ac_col[i] <= '1; ac_ctl[i] <= '0;
      end
    end else if (addr_hit) begin
      if (reg_id == 3'd7) pending <= 1'b1;
      else if (slot_ok)
        case (reg_id)
          3'd0: sh_xc[slot] <= data_in[X_W:0];
          3'd1: sh_yc[slot] <= data_in[Y_W:0];
          3'd2: sh_w[slot] <= data_in[X_W:0];
          3'd3: sh_h[slot] <= data_in[Y_W:0];
          3'd4: sh_col[slot] <= data_in;
          3'd5: sh_ctl[slot] <= data_in[1:0];
          default: ;
        endcase
    end else if (commit_now) begin
      pending <= 1'b0;
      ac_xc <= sh_xc; ac_yc <= sh_yc; ac_w <= sh_w; ac_h <= sh_h; ac_col <= sh_col; ac_ctl <= sh_ctl;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0; x1 <= '0; y1 <= '0; d1 <= '0; m1 <= '0; c1 <= '0; b1 <= 1'b0;
      program_out <= 1'b0; x_out <= '0; y_out <= '0; data_out <= '0;
    end else begin
      p1 <= program_in;
      x1 <= program_in ? x - 1'b1 : x;
      y1 <= y;
      d1 <= data_in;
      m1 <= hit;
      c1 <= sel_col;
      b1 <= sel_blend;
      program_out <= p1;
      x_out <= x1;
      y_out <= y1;
      data_out <= |m1 ? (b1 ? avg : c1) : d1;
    end
  end
endmodule

// File: tb/tb_multi_rect_renderer.sv
// tb_multi_rect_renderer: directed checks of programming, commit timing, priority and blending.
module tb_multi_rect_renderer;
  logic clk = 0, rst_n = 0, program_in = 1;
  logic [10:0] x = 11'd5;
  logic [11:0] y = '0;
  logic [31:0] data_in = '0;
  logic program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [31:0] data_out;
  int n_chk = 0, n_fail = 0;
  multi_rect_renderer #(.NUM_RECTS(3)) dut (
    .clk(clk), .rst_n(rst_n), .program_in(program_in), .x(x), .y(y), .data_in(data_in),
    .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drives one word, then an idle pass-through word, and returns when the first word's result is visible.
  task automatic xfer(input logic p, input logic [10:0] xx, input logic [11:0] yy, input logic [31:0] d);
    @(negedge clk);
    program_in = p; x = xx; y = yy; data_in = d;
    @(negedge clk);
    program_in = 1; x = 11'd5; y = '0; data_in = '0;
    @(negedge clk);
  endtask
  task automatic pix(input string tag, input int xx, input int yy, input logic [31:0] d, input logic [31:0] exp);
    xfer(0, 11'(xx), 12'(yy), d);
    check(tag, data_out, exp);
  endtask
  task automatic wr(input int slot, input int r, input logic [31:0] d);
    xfer(1, 11'd0, 12'(slot * 8 + r), d);
  endtask
  task automatic rect(input int slot, input int xc, input int yc, input int w, input int h, input logic [31:0] col, input int ctl);
    wr(slot, 0, 32'(xc)); wr(slot, 1, 32'(yc)); wr(slot, 2, 32'(w)); wr(slot, 3, 32'(h));
    wr(slot, 4, col); wr(slot, 5, 32'(ctl));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", data_out, 0);
    check("reset_prog", program_out, 0);
    check("reset_x", x_out, 0);
    rst_n = 1;
    pix("pass_basic", 5, 5, 32'h11223344, 32'h11223344);
    check("pass_prog", program_out, 0);
    check("pass_x", x_out, 5);
    check("pass_y", y_out, 5);
    rect(0, 10, 20, 4, 2, 32'hFF0000FF, 1);
    check("prog_xout", x_out, 11'h7FF);
    check("prog_data", data_out, 1);
    check("prog_pout", program_out, 1);
    check("prog_yout", y_out, 5);
    wr(0, 7, 0);
    pix("pre_frame", 10, 20, 32'hAAAA, 32'hAAAA);
    pix("frame_start", 0, 0, 32'h1, 32'h1);
    pix("in_corner0", 10, 20, 32'hAAAA, 32'hFF0000FF);
    pix("in_corner1", 13, 21, 32'hAAAA, 32'hFF0000FF);
    pix("out_right", 14, 20, 32'hBBBB, 32'hBBBB);
    pix("out_below", 10, 22, 32'hCCCC, 32'hCCCC);
    rect(0, 0, 0, 8, 8, 32'hFF000000, 1);
    rect(1, 0, 0, 8, 8, 32'h00FF0000, 1);
    wr(0, 7, 0);
    pix("ovl_fs", 0, 0, 32'h5, 32'h00FF0000);
    pix("ovl_77", 7, 7, 32'h5, 32'h00FF0000);
    pix("ovl_87", 8, 7, 32'h5, 32'h5);
    wr(1, 5, 0);
    wr(0, 7, 0);
    pix("ovl_disabled", 0, 0, 32'h5, 32'hFF000000);
    wr(0, 4, 32'h0000FF00);
    wr(0, 7, 0);
    pix("shadow_mid", 3, 3, 32'h5, 32'hFF000000);
    pix("shadow_fs", 0, 0, 32'h5, 32'h0000FF00);
    pix("shadow_after", 4, 4, 32'h5, 32'h0000FF00);
    wr(0, 4, 32'h80FF0002);
    wr(0, 5, 3);
    wr(0, 7, 0);
    pix("blend", 0, 0, 32'h00010004, 32'h40800003);
    xfer(1, 11'd3, 12'd4, 32'h12345678);
    check("other_stage_x", x_out, 2);
    check("other_stage_data", data_out, 32'h12345678);
    rect(3, 0, 0, 100, 100, 32'hDEADBEEF, 1);
    wr(0, 7, 0);
    pix("no_change_fs", 0, 0, 32'h00010004, 32'h40800003);
    pix("bad_slot", 50, 50, 32'h77, 32'h77);
    wr(0, 4, 32'h01010101);
    wr(0, 7, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midreset_data", data_out, 0);
    check("midreset_x", x_out, 0);
    @(negedge clk);
    rst_n = 1;
    pix("post_reset_fs", 0, 0, 32'h99, 32'h99);
    pix("post_reset_px", 1, 1, 32'h42, 32'h42);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
